// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg -- shared definitions for the write-back stage.
//   Default widths, RISC-V load funct3 encodings and the FSM state encoding
//   used by wb_stage and load_align.
package wb_stage_pkg;

   localparam int WB_DATA_W  = 64;
   localparam int WB_RADDR_W = 5;

   // Load type encodings carried in funct3.
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_RESP = 2'd1,
      ST_WRITE     = 2'd2
   } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align -- combinational load data extraction and extension.
//   funct3   : load type (LB/LH/LW/LD/LBU/LHU/LWU; 111 behaves as LD)
//   off      : load address bits [2:0]; offset bits below the access size
//              are ignored, there is no misalignment trap
//   rdata    : raw aligned doubleword from data memory
//   ext_data : selected lane, sign- or zero-extended to DATA_W
module load_align
   import wb_stage_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W
) (
   input  logic [2:0]        funct3,
   input  logic [2:0]        off,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] ext_data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] lane_w;

   always_comb begin
      // Lane selects: byte by off[2:0], half by off[2:1], word by off[2].
      lane_b = rdata[{off, 3'b000} +: 8];
      lane_h = rdata[{off[2:1], 4'b0000} +: 16];
      lane_w = rdata[{off[2], 5'b00000} +: 32];

      case (funct3)
         F3_LB:   ext_data = {{(DATA_W-8){lane_b[7]}}, lane_b};
         F3_LH:   ext_data = {{(DATA_W-16){lane_h[15]}}, lane_h};
         F3_LW:   ext_data = {{(DATA_W-32){lane_w[31]}}, lane_w};
         F3_LBU:  ext_data = {{(DATA_W-8){1'b0}}, lane_b};
         F3_LHU:  ext_data = {{(DATA_W-16){1'b0}}, lane_h};
         F3_LWU:  ext_data = {{(DATA_W-32){1'b0}}, lane_w};
         default: ext_data = rdata;   // LD and the unused 111 encoding
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// wb_stage -- write-back pipeline stage.
//   Accepts one instruction per cycle from MEM (valid/ready), waits for the
//   data-memory response on loads, and drives the register-file write port.
//
//   Handshake: an instruction transfers on a cycle where mem_valid_i and
//   mem_ready_o are both 1. mem_ready_o depends only on state (low while a
//   load waits for its response). dmem_rvalid_i has no ready; it is only
//   looked at while waiting for a response.
//
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     mem_*               instruction from MEM stage
//     dmem_rvalid_i/rdata data-memory read response
//     reg_wr_*            registered register-file write port
//     dbg_state_o         current FSM state (wb_state_e encoding)
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int DATA_W  = WB_DATA_W,
   parameter int RADDR_W = WB_RADDR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_valid_i,
   output logic               mem_ready_o,
   input  logic               mem_wr_en_i,
   input  logic [RADDR_W-1:0] mem_wr_addr_i,
   input  logic [DATA_W-1:0]  mem_alu_data_i,
   input  logic               mem_is_load_i,
   input  logic [2:0]         mem_funct3_i,
   input  logic [2:0]         mem_byte_off_i,
   input  logic               dmem_rvalid_i,
   input  logic [DATA_W-1:0]  dmem_rdata_i,
   output logic               reg_wr_en_o,
   output logic [RADDR_W-1:0] reg_wr_addr_o,
   output logic [DATA_W-1:0]  reg_wr_data_o,
   output logic [1:0]         dbg_state_o
);

   wb_state_e state_q, state_d;

   logic               accept;
   logic               resp;
   logic               alu_wr;
   logic               ld_wr;

   // Load fields held while the response is outstanding.
   logic               ld_wr_en_q;
   logic [RADDR_W-1:0] ld_addr_q;
   logic [2:0]         ld_funct3_q;
   logic [2:0]         ld_off_q;
   logic [DATA_W-1:0]  ld_data;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_WRITE: begin
            if (accept) state_d = mem_is_load_i ? ST_WAIT_RESP : ST_WRITE;
            else        state_d = ST_IDLE;
         end
         ST_WAIT_RESP: begin
            if (dmem_rvalid_i) state_d = ST_WRITE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      mem_ready_o = (state_q != ST_WAIT_RESP);
      dbg_state_o = state_q;
   end

   assign accept = mem_valid_i & mem_ready_o;
   assign resp   = (state_q == ST_WAIT_RESP) & dmem_rvalid_i;

   // Register x0 is never written: the register file forwards by address
   // match, so a stray x0 write would leak a nonzero value to readers.
   assign alu_wr = accept & ~mem_is_load_i & mem_wr_en_i & (mem_wr_addr_i != '0);
   assign ld_wr  = resp & ld_wr_en_q & (ld_addr_q != '0);

   // ---------------- load capture ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_wr_en_q  <= 1'b0;
         ld_addr_q   <= '0;
         ld_funct3_q <= '0;
         ld_off_q    <= '0;
      end else if (accept && mem_is_load_i) begin
         ld_wr_en_q  <= mem_wr_en_i;
         ld_addr_q   <= mem_wr_addr_i;
         ld_funct3_q <= mem_funct3_i;
         ld_off_q    <= mem_byte_off_i;
      end
   end

   load_align #(.DATA_W(DATA_W)) u_load_align (
      .funct3   (ld_funct3_q),
      .off      (ld_off_q),
      .rdata    (dmem_rdata_i),
      .ext_data (ld_data)
   );

   // ---------------- write port ----------------
   // The write port is loaded on the edge that enters WRITE, so it is live
   // exactly for the WRITE cycle. Address/data hold their last written
   // values otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_wr_en_o   <= 1'b0;
         reg_wr_addr_o <= '0;
         reg_wr_data_o <= '0;
      end else begin
         reg_wr_en_o <= alu_wr | ld_wr;
         if (alu_wr) begin
            reg_wr_addr_o <= mem_wr_addr_i;
            reg_wr_data_o <= mem_alu_data_i;
         end else if (ld_wr) begin
            reg_wr_addr_o <= ld_addr_q;
            reg_wr_data_o <= ld_data;
         end
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage -- self-checking bench for wb_stage: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_wb_stage;
   import wb_stage_pkg::*;

   localparam int DW = 64;
   localparam int AW = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          mem_valid_i, mem_ready_o, mem_wr_en_i, mem_is_load_i;
   logic [AW-1:0] mem_wr_addr_i;
   logic [DW-1:0] mem_alu_data_i;
   logic [2:0]    mem_funct3_i, mem_byte_off_i;
   logic          dmem_rvalid_i;
   logic [DW-1:0] dmem_rdata_i;
   logic          reg_wr_en_o;
   logic [AW-1:0] reg_wr_addr_o;
   logic [DW-1:0] reg_wr_data_o;
   logic [1:0]    dbg_state_o;

   wb_stage #(.DATA_W(DW), .RADDR_W(AW)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_valid_i    (mem_valid_i),
      .mem_ready_o    (mem_ready_o),
      .mem_wr_en_i    (mem_wr_en_i),
      .mem_wr_addr_i  (mem_wr_addr_i),
      .mem_alu_data_i (mem_alu_data_i),
      .mem_is_load_i  (mem_is_load_i),
      .mem_funct3_i   (mem_funct3_i),
      .mem_byte_off_i (mem_byte_off_i),
      .dmem_rvalid_i  (dmem_rvalid_i),
      .dmem_rdata_i   (dmem_rdata_i),
      .reg_wr_en_o    (reg_wr_en_o),
      .reg_wr_addr_o  (reg_wr_addr_o),
      .reg_wr_data_o  (reg_wr_data_o),
      .dbg_state_o    (dbg_state_o)
   );

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [AW+DW-1:0] exp_q[$];   // {addr, data} of each expected write, in order

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic          m_busy;        // a load is waiting for its response
   logic          m_wr_en;
   logic [AW-1:0] m_addr;
   logic [2:0]    m_f3, m_off;
   logic          exp_en;
   logic [1:0]    exp_state;
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_data;

   // Load result from plain arithmetic: access size from funct3[1:0],
   // offset rounded down to the size, shift, mask, then extend.
   function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] off,
                                            input logic [63:0] rdata);
      int sz;
      int base;
      logic [63:0] v;
      logic [63:0] mask;
      sz   = 1 << f3[1:0];
      base = (int'(off) / sz) * sz;
      v    = rdata >> (base * 8);
      if (sz < 8) begin
         mask = (64'd1 << (sz * 8)) - 64'd1;
         v    = v & mask;
         if (!f3[2] && v[sz*8-1]) v = v | ~mask;
      end
      return v;
   endfunction

   task automatic model_reset();
      m_busy    = 1'b0;
      m_wr_en   = 1'b0;
      m_addr    = '0;
      m_f3      = '0;
      m_off     = '0;
      exp_en    = 1'b0;
      exp_state = ST_IDLE;
      last_addr = '0;
      last_data = '0;
      exp_q.delete();
   endtask

   task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_q.push_back({a, d});
      last_addr = a;
      last_data = d;
   endtask

   // ---------------- driver ----------------
   task automatic drive_idle();
      mem_valid_i    = 1'b0;
      mem_wr_en_i    = 1'b0;
      mem_wr_addr_i  = '0;
      mem_alu_data_i = '0;
      mem_is_load_i  = 1'b0;
      mem_funct3_i   = '0;
      mem_byte_off_i = '0;
      dmem_rvalid_i  = 1'b0;
      dmem_rdata_i   = '0;
   endtask

   // One clock cycle. Entered #1 after a rising edge: first checks the
   // outputs of the current cycle, then applies inputs, predicts the next
   // cycle and advances to #1 after the next rising edge.
   task automatic cycle(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] alu, input logic ld, input logic [2:0] f3,
                        input logic [2:0] off, input logic rv, input logic [DW-1:0] rd);
      logic [AW+DW-1:0] e;
      logic             n_en;
      logic [1:0]       n_state;

      chk("ready", mem_ready_o, !m_busy);
      chk("state", dbg_state_o, exp_state);
      chk("wr_en", reg_wr_en_o, exp_en);
      chk("addr_hold", reg_wr_addr_o, last_addr);
      chk("data_hold", reg_wr_data_o, last_data);
      if (reg_wr_en_o) begin
         if (exp_q.size() == 0) chk("spurious_wr", 1'b1, 1'b0);
         else begin
            e = exp_q.pop_front();
            chk("wr_addr", reg_wr_addr_o, e[AW+DW-1:DW]);
            chk("wr_data", reg_wr_data_o, e[DW-1:0]);
         end
      end

      mem_valid_i    = v;
      mem_wr_en_i    = we;
      mem_wr_addr_i  = a;
      mem_alu_data_i = alu;
      mem_is_load_i  = ld;
      mem_funct3_i   = f3;
      mem_byte_off_i = off;
      dmem_rvalid_i  = rv;
      dmem_rdata_i   = rd;

      n_en    = 1'b0;
      n_state = ST_IDLE;
      if (!m_busy) begin
         if (v && ld) begin
            m_busy  = 1'b1;
            m_wr_en = we;
            m_addr  = a;
            m_f3    = f3;
            m_off   = off;
            n_state = ST_WAIT_RESP;
         end else if (v) begin
            n_state = ST_WRITE;
            if (we && a != 0) begin
               n_en = 1'b1;
               push_write(a, alu);
            end
         end
      end else if (rv) begin
         m_busy  = 1'b0;
         n_state = ST_WRITE;
         if (m_wr_en && m_addr != 0) begin
            n_en = 1'b1;
            push_write(m_addr, ref_load(m_f3, m_off, rd));
         end
      end else begin
         n_state = ST_WAIT_RESP;
      end
      exp_en    = n_en;
      exp_state = n_state;

      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 3'b000, 3'b000, 1'b0, '0);
   endtask

   task automatic alu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cycle(1'b1, we, a, d, 1'b0, 3'b000, 3'b000, 1'b0, '0);
   endtask

   task automatic load_op(input logic [AW-1:0] a, input logic [2:0] f3, input logic [2:0] off);
      cycle(1'b1, 1'b1, a, '0, 1'b1, f3, off, 1'b0, '0);
   endtask

   task automatic respond(input logic [DW-1:0] rd);
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 3'b000, 3'b000, 1'b1, rd);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear at once.
   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      #2;
      chk("rst_wr_en", reg_wr_en_o, 1'b0);
      chk("rst_addr", reg_wr_addr_o, '0);
      chk("rst_data", reg_wr_data_o, '0);
      chk("rst_ready", mem_ready_o, 1'b1);
      chk("rst_state", dbg_state_o, ST_IDLE);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic          v, we, ld, rv;
      logic [AW-1:0] a;
      logic [2:0]    f3, off;

      drive_idle();
      model_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // ADD rd=5 accepted on cycle 10, written on cycle 11 only.
      repeat (9) idle();
      alu_op(1'b1, 5'd5, 64'h1234);
      chk("add_en", reg_wr_en_o, 1'b1);
      chk("add_addr", reg_wr_addr_o, 64'd5);
      chk("add_data", reg_wr_data_o, 64'h1234);
      idle();
      chk("add_en_off", reg_wr_en_o, 1'b0);

      // LB / LBU at offset 3.
      load_op(5'd7, F3_LB, 3'd3);
      respond(64'h00000000_80000000);
      chk("lb_data", reg_wr_data_o, 64'hFFFFFFFF_FFFFFF80);
      load_op(5'd7, F3_LBU, 3'd3);
      respond(64'h00000000_80000000);
      chk("lbu_data", reg_wr_data_o, 64'h80);

      // LW at offset 4 with a slow response; MEM keeps offering work.
      load_op(5'd9, F3_LW, 3'd4);
      repeat (5) begin
         chk("lw_wait_ready", mem_ready_o, 1'b0);
         cycle(1'b1, 1'b1, 5'd3, 64'h55, 1'b0, 3'b000, 3'b000, 1'b0, '0);
      end
      chk("lw_wait_ready", mem_ready_o, 1'b0);
      respond(64'h8000_0001_0000_0000);
      chk("lw_data", reg_wr_data_o, 64'hFFFFFFFF_80000001);

      // Write to x0 is suppressed.
      alu_op(1'b1, 5'd0, 64'hDEAD);
      chk("x0_en", reg_wr_en_o, 1'b0);
      idle();

      // Reset while a load waits; a late response must be ignored.
      load_op(5'd4, F3_LD, 3'd0);
      idle();
      do_reset();
      respond(64'hFFFF_FFFF_FFFF_FFFF);
      chk("rst_resp_en", reg_wr_en_o, 1'b0);
      chk("rst_resp_state", dbg_state_o, ST_IDLE);
      chk("rst_resp_ready", mem_ready_o, 1'b1);

      // Three back-to-back non-loads.
      alu_op(1'b1, 5'd1, 64'h11);
      chk("b2b1", {reg_wr_en_o, reg_wr_addr_o}, {1'b1, 5'd1});
      alu_op(1'b1, 5'd2, 64'h22);
      chk("b2b2", {reg_wr_en_o, reg_wr_addr_o}, {1'b1, 5'd2});
      alu_op(1'b1, 5'd3, 64'h33);
      chk("b2b3", {reg_wr_en_o, reg_wr_addr_o}, {1'b1, 5'd3});
      idle();
      chk("b2b_end", reg_wr_en_o, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         v   = ($urandom_range(0, 3) != 0);
         we  = ($urandom_range(0, 4) != 0);
         ld  = ($urandom_range(0, 2) == 0);
         a   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         f3  = 3'($urandom_range(0, 7));
         off = 3'($urandom_range(0, 7));
         rv  = ($urandom_range(0, 2) == 0);
         cycle(v, we, a, {$urandom, $urandom}, ld, f3, off, rv, {$urandom, $urandom});
      end

      // Drain any outstanding load, then flush the write port.
      if (m_busy) respond({$urandom, $urandom});
      idle();
      idle();
      chk("q_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning register/data width.
REQ-002 SHALL have parameter RADDR_W, default 5, meaning register address width.
REQ-003 SHALL run on one clock; reset is asynchronous and active-high.
REQ-004 SHALL provide the following ports:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- mem_valid_i  in  1  MEM-stage instruction valid.
- mem_ready_o  out  1  stage accepts instruction this cycle.
- mem_wr_en_i  in  1  instruction writes rd.
- mem_wr_addr_i  in  RADDR_W  rd index.
- mem_alu_data_i  in  DATA_W  non-load result.
- mem_is_load_i  in  1  instruction is a load.
- mem_funct3_i  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- mem_byte_off_i  in  3  load address bits [2:0].
- dmem_rvalid_i  in  1  data-memory read response valid.
- dmem_rdata_i  in  DATA_W  raw aligned 64-bit doubleword.
- reg_wr_en_o  out  1  register-file write enable.
- reg_wr_addr_o  out  RADDR_W  register-file write address.
- reg_wr_data_o  out  DATA_W  register-file write data.

Function
REQ-005 SHALL implement FSM states IDLE, WAIT_RESP, WRITE.
REQ-006 SHALL accept an instruction on a cycle where mem_valid_i and mem_ready_o are both 1.
REQ-007 SHALL drive mem_ready_o combinationally: 1 in IDLE and WRITE, 0 in WAIT_RESP.
REQ-008 SHALL use these transitions from IDLE or WRITE:
- accept non-load -> WRITE.
- accept load -> WAIT_RESP.
- no accept -> IDLE.
REQ-009 SHALL hold WAIT_RESP until dmem_rvalid_i=1, then go to WRITE.
REQ-010 SHALL ignore dmem_rvalid_i outside WAIT_RESP.
REQ-011 SHALL give non-load latency of exactly 1 cycle: accept at cycle N -> write port active during cycle N+1 only.
REQ-012 SHALL give load latency of 1 cycle after response: response sampled at cycle M -> write during M+1.
REQ-013 SHALL sustain back-to-back non-loads at one write per cycle.
REQ-014 SHALL assert reg_wr_en_o only in WRITE, and only if the captured wr_en=1 and captured addr!=0.
- Forcing x0 writes off is mandatory; the register file forwards write data to readers by address match.
REQ-015 SHALL still consume the response and a WRITE cycle for a load with wr_en=0, with reg_wr_en_o=0.
REQ-016 SHALL extract load data by byte lane:
- byte: lane = off[2:0].
- half: lane = off[2:1].
- word: lane = off[2].
- off LSBs below access size are ignored (no misalign trap).
REQ-017 SHALL sign-extend LB/LH/LW, zero-extend LBU/LHU/LWU, and pass LD unchanged; funct3=111 SHALL be treated as LD.
REQ-018 SHALL present reg_wr_addr_o and reg_wr_data_o as registered values, holding the last written values when reg_wr_en_o=0.

Reset
REQ-019 SHALL on rst=1 immediately force:
- state IDLE.
- reg_wr_en_o=0, reg_wr_addr_o=0, reg_wr_data_o=0.
- mem_ready_o=1.
REQ-020 SHALL discard a load pending in WAIT_RESP on reset; a response arriving after reset deassertion SHALL be ignored.

Structure
REQ-021 SHALL take DATA_W/RADDR_W defaults, funct3 load encodings and FSM state encodings from the shared defines header.
REQ-022 SHALL place load extraction/extension in one combinational sub-module, load_align (inputs funct3, off, rdata; output extended data).

Verification
REQ-023 SHALL check: ADD result 0x1234, rd=5, accepted cycle 10 -> cycle 11 wr_en=1 addr=5 data=0x1234; cycle 12 wr_en=0.
REQ-024 SHALL check: LB off=3, rdata=0x00000000_80000000 -> after rvalid, data=0xFFFFFFFF_FFFFFF80; same with LBU -> 0x80.
REQ-025 SHALL check: LW off=4, rvalid held low 5 cycles:
- mem_ready_o=0 throughout.
- rdata=0x8000_0001_0000_0000 -> data=0xFFFFFFFF_80000001.
REQ-026 SHALL check: non-load with rd=0, wr_en=1, data=0xDEAD -> reg_wr_en_o stays 0.
REQ-027 SHALL check: rst pulsed while in WAIT_RESP, then rvalid=1 -> no write, state IDLE, ready=1.
REQ-028 SHALL check: three back-to-back non-loads rd=1,2,3 -> writes on three consecutive cycles in order.
